// File: rtl/lr35902_oam_dma.sv
// OAM DMA controller: a write to I/O register 'h46 copies LEN bytes from page {src, 8'h00}
// into OAM, one byte per arbitrated read followed by a single-cycle OAM write.
module lr35902_oam_dma #(
    parameter int unsigned LEN = 160
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  din,
    input  logic [7:0]  adr,
    input  logic        read,
    input  logic        write,
    output logic [7:0]  dout,
    output logic        dma_active,
    output logic        bus_req,
    input  logic        bus_gnt,
    output logic [15:0] mem_adr,
    output logic        mem_rd,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ack,
    output logic [7:0]  oam_adr,
    output logic [7:0]  oam_wdata,
    output logic        oam_we
);

    localparam logic [7:0] RegDma = 8'h46;
    localparam logic [7:0] Last   = 8'(LEN - 1);

    typedef enum logic [1:0] {StIdle, StReq, StWr} state_t;

    state_t     state;
    logic [7:0] src;
    logic [7:0] idx;
    logic [7:0] data;
    logic [7:0] page;
    logic       dma_wr;

    assign dma_wr = write && (adr == RegDma);

    // Echo RAM pages E0..FF fold back onto the work RAM at C0..DF.
    assign page = (src < 8'hE0) ? src : (src - 8'h20);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= StIdle;
            src   <= 8'h00;
            idx   <= 8'h00;
            data  <= 8'h00;
            dout  <= 8'h00;
        end else begin
            if (read) begin
                dout <= (adr == RegDma) ? src : 8'hFF;
            end
            // A register write restarts from any state and drops any byte acked this cycle.
            if (dma_wr) begin
                src   <= din;
                idx   <= 8'h00;
                state <= StReq;
            end else begin
                case (state)
                    StReq: begin
                        if (mem_rd && mem_ack) begin
                            data  <= mem_rdata;
                            state <= StWr;
                        end
                    end
                    StWr: begin
                        if (idx == Last) begin
                            state <= StIdle;
                        end else begin
                            idx   <= idx + 8'd1;
                            state <= StReq;
                        end
                    end
                    default: state <= StIdle;
                endcase
            end
        end
    end

    assign dma_active = (state == StReq) || (state == StWr);
    assign bus_req    = dma_active;
    assign mem_rd     = (state == StReq) && bus_gnt;
    assign mem_adr    = {page, idx};
    assign oam_we     = (state == StWr);
    assign oam_adr    = idx;
    assign oam_wdata  = data;

endmodule

// File: tb/tb_lr35902_oam_dma.sv
// Directed bench for lr35902_oam_dma: full copies, echo-page folding, grant stall,
// restart during a write and reset mid-transfer.
module tb_lr35902_oam_dma;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  din;
    logic [7:0]  adr;
    logic        read;
    logic        write;
    logic [7:0]  dout;
    logic        dma_active;
    logic        bus_req;
    logic        bus_gnt;
    logic [15:0] mem_adr;
    logic        mem_rd;
    logic [7:0]  mem_rdata;
    logic        mem_ack;
    logic [7:0]  oam_adr;
    logic [7:0]  oam_wdata;
    logic        oam_we;

    int checks = 0;
    int errors = 0;

    logic [7:0]  we_adr[$];
    logic [7:0]  we_dat[$];
    logic [15:0] ack_adr[$];

    always #5 clk = ~clk;

    // Memory model: every byte holds the low byte of its address, acked immediately.
    assign mem_rdata = mem_adr[7:0];
    assign mem_ack   = mem_rd;

    lr35902_oam_dma #(.LEN(160)) dut (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
        .adr        (adr),
        .read       (read),
        .write      (write),
        .dout       (dout),
        .dma_active (dma_active),
        .bus_req    (bus_req),
        .bus_gnt    (bus_gnt),
        .mem_adr    (mem_adr),
        .mem_rd     (mem_rd),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .oam_adr    (oam_adr),
        .oam_wdata  (oam_wdata),
        .oam_we     (oam_we)
    );

    always @(negedge clk) begin
        if (oam_we) begin
            we_adr.push_back(oam_adr);
            we_dat.push_back(oam_wdata);
        end
        if (mem_rd && mem_ack) ack_adr.push_back(mem_adr);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        we_adr.delete();
        we_dat.delete();
        ack_adr.delete();
    endtask

    task automatic cpu_write(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        adr = a; din = d; write = 1'b1;
        @(negedge clk);
        write = 1'b0;
    endtask

    task automatic cpu_read(input logic [7:0] a);
        @(negedge clk);
        adr = a; read = 1'b1;
        @(negedge clk);
        read = 1'b0;
    endtask

    task automatic wait_idle(input string tag, output int n);
        n = 0;
        while (dma_active && n < 2000) begin
            n++;
            @(negedge clk);
        end
        chk(tag, 32'(n < 2000), 32'd1);
    endtask

    task automatic wait_req(input string tag, input logic [15:0] a);
        int t = 0;
        while (!(mem_rd && mem_adr == a) && t < 1000) begin
            t++;
            @(negedge clk);
        end
        chk(tag, 32'(t < 1000), 32'd1);
    endtask

    task automatic wait_wr(input string tag, input logic [7:0] i);
        int t = 0;
        while (!(oam_we && oam_adr == i) && t < 1000) begin
            t++;
            @(negedge clk);
        end
        chk(tag, 32'(t < 1000), 32'd1);
    endtask

    initial begin
        int n;
        int bad;
        int cnt5;
        int snap;
        logic stall_ok;

        reset = 1'b1; din = 8'h00; adr = 8'h00; read = 1'b0; write = 1'b0; bus_gnt = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_dout", 32'(dout), 32'h00);
        chk("rst_active", 32'(dma_active), 32'd0);
        chk("rst_bus_req", 32'(bus_req), 32'd0);
        chk("rst_oam_we", 32'(oam_we), 32'd0);
        chk("rst_mem_rd", 32'(mem_rd), 32'd0);
        chk("rst_mem_adr", 32'(mem_adr), 32'h0000);

        // Full copy from page C1.
        bus_gnt = 1'b1;
        clear_logs();
        cpu_write(8'h46, 8'hC1);
        chk("start_active", 32'(dma_active), 32'd1);
        chk("start_bus_req", 32'(bus_req), 32'd1);
        wait_idle("full_done", n);
        chk("full_active_cycles", 32'(n), 32'd320);
        chk("full_we_count", 32'(we_adr.size()), 32'd160);
        chk("full_ack_count", 32'(ack_adr.size()), 32'd160);
        bad = 0;
        for (int i = 0; i < 160 && i < we_adr.size() && i < ack_adr.size(); i++) begin
            if (we_adr[i] !== 8'(i) || we_dat[i] !== 8'(i) || ack_adr[i] !== 16'hC100 + 16'(i))
                bad++;
        end
        chk("full_contents_bad", 32'(bad), 32'd0);

        // Echo page FE folds to DE; register readback.
        cpu_write(8'h46, 8'hFE);
        chk("echo_mem_adr", 32'(mem_adr), 32'hDE00);
        cpu_read(8'h46);
        chk("read_46", 32'(dout), 32'hFE);
        cpu_read(8'h47);
        chk("read_47", 32'(dout), 32'hFF);
        wait_idle("echo_done", n);

        // Grant withheld for 10 cycles while requesting idx 5.
        clear_logs();
        cpu_write(8'h46, 8'hC1);
        wait_req("stall_find", 16'hC105);
        bus_gnt = 1'b0;
        stall_ok = 1'b1;
        repeat (10) begin
            #1;
            if (mem_rd !== 1'b0 || bus_req !== 1'b1 || mem_adr !== 16'hC105) stall_ok = 1'b0;
            @(negedge clk);
        end
        chk("stall_outputs", 32'(stall_ok), 32'd1);
        bus_gnt = 1'b1;
        wait_idle("stall_done", n);
        cnt5 = 0;
        bad = 0;
        for (int i = 0; i < we_adr.size(); i++) begin
            if (we_adr[i] == 8'd5) begin
                cnt5++;
                if (we_dat[i] !== 8'h05) bad++;
            end
        end
        chk("stall_idx5_writes", 32'(cnt5), 32'd1);
        chk("stall_idx5_data_bad", 32'(bad), 32'd0);
        chk("stall_we_count", 32'(we_adr.size()), 32'd160);

        // Restart with page 80 during the OAM write of idx 40.
        clear_logs();
        cpu_write(8'h46, 8'hC1);
        wait_wr("restart_find", 8'd40);
        adr = 8'h46; din = 8'h80; write = 1'b1;
        @(negedge clk);
        write = 1'b0;
        chk("restart_mem_adr", 32'(mem_adr), 32'h8000);
        chk("restart_mem_rd", 32'(mem_rd), 32'd1);
        wait_idle("restart_done", n);
        chk("restart_we_count", 32'(we_adr.size()), 32'd201);
        if (we_adr.size() >= 41) begin
            chk("restart_old_adr40", 32'(we_adr[40]), 32'd40);
            chk("restart_old_dat40", 32'(we_dat[40]), 32'd40);
        end
        if (ack_adr.size() >= 42) chk("restart_first_ack", 32'(ack_adr[41]), 32'h8000);
        bad = 0;
        for (int i = 41; i < 201 && i < we_adr.size(); i++) begin
            if (we_adr[i] !== 8'(i - 41) || we_dat[i] !== 8'(i - 41)) bad++;
        end
        chk("restart_new_bad", 32'(bad), 32'd0);

        // Reset pulse while requesting idx 77.
        clear_logs();
        cpu_write(8'h46, 8'hC1);
        wait_req("reset_find", 16'hC14D);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("reset_active", 32'(dma_active), 32'd0);
        chk("reset_bus_req", 32'(bus_req), 32'd0);
        chk("reset_mem_rd", 32'(mem_rd), 32'd0);
        chk("reset_oam_we", 32'(oam_we), 32'd0);
        snap = we_adr.size();
        repeat (50) @(negedge clk);
        chk("reset_no_writes", 32'(we_adr.size()), 32'(snap));
        chk("reset_we_before", 32'(snap), 32'd77);
        cpu_read(8'h46);
        chk("reset_read_46", 32'(dout), 32'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lr35902_oam_dma.md
# lr35902_oam_dma

OAM DMA controller for the LR35902 system, owning I/O register 'h46 alongside the PPU registers ('h40..'h4b). A write to 'h46 copies 160 bytes from source page {din, 8'h00} into OAM ('hFE00..'hFE9F). The copy runs one byte at a time through a request/grant handshake with the system memory arbiter, and each byte is written to the OAM port. The block raises `dma_active` so the CPU bus logic can restrict CPU accesses during the copy.

## Interface
Parameters:
- `LEN`, default 160: number of bytes per transfer.

Ports:
- `clk`  in  1  system clock
- `reset`  in  1  reset, synchronous, active-high
- `din`  in  8  CPU I/O write data
- `adr`  in  8  CPU I/O address (low byte of 'hFFxx)
- `read`  in  1  CPU I/O read strobe
- `write`  in  1  CPU I/O write strobe
- `dout`  out  8  CPU I/O read data
- `dma_active`  out  1  transfer in progress
- `bus_req`  out  1  request for system memory bus
- `bus_gnt`  in  1  grant from arbiter
- `mem_adr`  out  16  source read address
- `mem_rd`  out  1  source read strobe
- `mem_rdata`  in  8  source read data, valid when `mem_ack`
- `mem_ack`  in  1  read completion; ignored unless `mem_rd` is high
- `oam_adr`  out  8  OAM byte index, 0..LEN-1
- `oam_wdata`  out  8  OAM write data
- `oam_we`  out  1  OAM write strobe, one clk per byte

## Operation
Registers:
- `src[7:0]`: last value written to 'h46.
- `idx[7:0]`: byte index.
- `data[7:0]`: latched read byte.
- `state`: one of IDLE, REQ, WR.

Source address:
- `mem_adr = {page, idx}`, where `page = src` if `src < 'hE0`, otherwise `src - 'h20`. Pages E0..FF therefore fold onto C0..DF.

Register access:
- **Write:** `write && adr=='h46` sets `src <= din`, `idx <= 0`, `state <= REQ`. This applies from any state and is a restart when a transfer is already running.
- **Read:** `read && adr=='h46` sets `dout <= src`. `read` with any other `adr` sets `dout <= 'hFF`. `dout` holds its value when `read` is low.

States (Moore outputs):
- **IDLE:** all strobes low, `dma_active=0`.
- **REQ:**
  - Outputs: `bus_req=1`, `dma_active=1`, `mem_rd=bus_gnt`.
  - When `mem_rd && mem_ack`: `data <= mem_rdata`, go to WR.
  - Otherwise stay in REQ. If `bus_gnt` drops, `mem_rd` drops the same cycle and the read is retried when grant returns.
- **WR:**
  - Outputs: `oam_we=1`, `oam_adr=idx`, `oam_wdata=data`, `bus_req=1`, `dma_active=1`.
  - Next: if `idx==LEN-1`, go to IDLE; otherwise `idx <= idx+1` and go to REQ.

Simultaneous events:
- **Restart write while in WR:** the OAM write of that cycle still happens. Next state is REQ with `idx=0` and the new `src`.
- **Restart write while in REQ with `mem_ack` in the same cycle:** the acked byte is discarded. Next state is REQ with `idx=0`.

Width rules:
- `idx` never exceeds LEN-1.
- `oam_adr` equals `idx`. There is no wrap beyond LEN.

## Timing
- **Reset values:** `state=IDLE`, `src=0`, `idx=0`, `data=0`, `dout=0`; all strobes, `bus_req` and `dma_active` are 0.
- **Reset mid-transfer:** takes effect at the next edge. From the following cycle all outputs are at reset values and no further `oam_we` is issued.
- **Start latency:** write sampled at edge N gives REQ with `bus_req=1` and `dma_active=1` in the cycle after N.
- **Per byte:** at least 2 clk (one REQ cycle with same-cycle `gnt`/`ack`, one WR cycle).
- **Full transfer:** at least 2*LEN = 320 clk. `dma_active` falls in the cycle after the last WR.
- **`mem_adr`:** stable throughout REQ, including wait cycles.
- **`dout` latency:** one clk after the `read` sample.

## Test plan
- Write 'h46='hC1 with `bus_gnt=1` and `mem_ack=mem_rd`, memory byte = low address byte.
  - Required: 160 `oam_we` pulses; byte i writes `oam_adr=i` with data i; `mem_adr` runs 'hC100..'hC19F.
  - Required: `dma_active` is high for exactly 320 clk.
- Write 'h46='hFE.
  - Required: `mem_adr` starts at 'hDE00.
  - Required: reading 'h46 returns 'hFE; reading 'h47 returns 'hFF.
- Hold `bus_gnt=0` for 10 clk at idx 5.
  - Required: `mem_rd=0` and `bus_req=1` during the stall; `mem_adr` stays 'hC105.
  - Required: after grant returns, idx 5 is written once with the correct data.
- Restart with 'h46='h80 during WR of idx 40.
  - Required: idx 40 is written with the old data.
  - Required: the next read is 'h8000, followed by 160 writes from index 0.
- Assert `reset` for 1 clk during REQ at idx 77.
  - Required: from the following cycle, `dma_active`, `bus_req`, `mem_rd` and `oam_we` are all 0.
  - Required: no further OAM writes; a subsequent read of 'h46 returns 'h00.
